// File: rtl/config_pkg.sv
// Shared definitions for the tile configuration bus driver: block types, header layout, FSM states.
// The ST_CHK state exists only when CONFIG_CHECKSUM_EN is defined.
package config_pkg;

   localparam logic [15:0] CONFIG_SB  = 16'd7;
   localparam logic [15:0] CONFIG_CB0 = 16'd6;
   localparam logic [15:0] CONFIG_CB1 = 16'd5;
   localparam logic [15:0] CONFIG_CLB = 16'd4;

   localparam logic [15:0] HDR_MAGIC = 16'hC0F1;
   localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

   localparam int HDR_MAGIC_MSB = 31;
   localparam int HDR_MAGIC_LSB = 16;
   localparam int HDR_COUNT_MSB = 15;
   localparam int HDR_COUNT_LSB = 0;

`ifdef CONFIG_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_ADDR, ST_DATA, ST_WRITE, ST_CHK, ST_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_ADDR, ST_DATA, ST_WRITE, ST_DONE
   } state_t;
`endif

endpackage

// File: rtl/config_xor_accum.sv
// 32-bit running XOR over the addr/data words of one configuration load.
module config_xor_accum (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [31:0] word,
   output logic [31:0] sum
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sum <= '0;
      end else if (enable) begin
         sum <= sum ^ word;
      end
   end

endmodule

// File: rtl/config_bus_driver.sv
// Configuration-bus master: turns a header + (addr, data) word stream into held tile config writes.
// Define CONFIG_CHECKSUM_EN to require and verify a trailing XOR checksum word.
//
// state | meaning
// IDLE  | bus parked, waiting for start
// HDR   | accept header word (magic + pair count)
// ADDR  | accept address word of next pair
// DATA  | accept data word, launch write
// WRITE | write held on bus for HOLD_CYCLES
// CHK   | accept trailing checksum word (CONFIG_CHECKSUM_EN only)
// DONE  | one-cycle done pulse
module config_bus_driver #(
   parameter logic [31:0] IDLE_ADDR   = config_pkg::IDLE_ADDR,
   parameter int          HOLD_CYCLES = 1,
   parameter logic [15:0] HDR_MAGIC   = config_pkg::HDR_MAGIC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] pairs_written
);

   import config_pkg::*;

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef CONFIG_CHECKSUM_EN
   localparam state_t ST_TAIL    = ST_CHK;
   localparam logic   TAIL_READY = 1'b1;
`else
   localparam state_t ST_TAIL    = ST_DONE;
   localparam logic   TAIL_READY = 1'b0;
`endif

   state_t              state;
   logic [15:0]         remaining;
   logic [31:0]         addr_q;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                xfer;

   assign xfer = in_valid && in_ready;

`ifdef CONFIG_CHECKSUM_EN
   logic [31:0] xor_sum;

   config_xor_accum u_xor_accum (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == ST_IDLE && start),
      .enable (xfer && (state == ST_ADDR || state == ST_DATA)),
      .word   (in_data),
      .sum    (xor_sum)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         config_addr   <= IDLE_ADDR;
         config_data   <= '0;
         in_ready      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         pairs_written <= '0;
         remaining     <= '0;
         addr_q        <= '0;
         hold_cnt      <= '0;
      end else if (abort && state != ST_IDLE) begin
         // Truncate any in-flight write; err and pairs_written keep their values.
         state       <= ST_IDLE;
         config_addr <= IDLE_ADDR;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state         <= ST_HDR;
                  in_ready      <= 1'b1;
                  busy          <= 1'b1;
                  err           <= 1'b0;
                  pairs_written <= '0;
               end
            end
            ST_HDR: begin
               if (xfer) begin
                  if (in_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != HDR_MAGIC) begin
                     err      <= 1'b1;
                     state    <= ST_DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                  end else if (in_data[HDR_COUNT_MSB:HDR_COUNT_LSB] == '0) begin
                     state    <= ST_TAIL;
                     in_ready <= TAIL_READY;
                     done     <= !TAIL_READY;
                  end else begin
                     remaining <= in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
                     state     <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (xfer) begin
                  addr_q <= in_data;
                  state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  config_addr   <= addr_q;
                  config_data   <= in_data;
                  hold_cnt      <= HOLD_W'(HOLD_CYCLES - 1);
                  pairs_written <= pairs_written + 16'd1;
                  remaining     <= remaining - 16'd1;
                  state         <= ST_WRITE;
                  in_ready      <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (hold_cnt == '0) begin
                  config_addr <= IDLE_ADDR;
                  if (remaining == '0) begin
                     state    <= ST_TAIL;
                     in_ready <= TAIL_READY;
                     done     <= !TAIL_READY;
                  end else begin
                     state    <= ST_ADDR;
                     in_ready <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
`ifdef CONFIG_CHECKSUM_EN
            ST_CHK: begin
               if (xfer) begin
                  if (in_data != xor_sum) begin
                     err <= 1'b1;
                  end
                  state    <= ST_DONE;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               config_addr <= IDLE_ADDR;
               in_ready    <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_bus_driver.sv
// Directed bench for config_bus_driver: instance 0 with HOLD_CYCLES=1, instance 1 with HOLD_CYCLES=3.
// Expected bus writes are queued when the data word is driven and checked by a bus monitor.
module tb_config_bus_driver;

   import config_pkg::*;

   localparam logic [31:0] PARK = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start [2];
   logic        abort [2];
   logic        in_valid [2];
   logic [31:0] in_data [2];
   logic        in_ready [2];
   logic [31:0] config_addr [2];
   logic [31:0] config_data [2];
   logic        busy [2];
   logic        done [2];
   logic        err [2];
   logic [15:0] pairs_written [2];

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] q0 [$];
   logic [63:0] q1 [$];
   logic        was_act [2];
   int          plen [2];
`ifdef CONFIG_CHECKSUM_EN
   logic [31:0] xm [2];
`endif

   always #5 clk = ~clk;

   config_bus_driver #(.HOLD_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .config_addr(config_addr[0]), .config_data(config_data[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]), .pairs_written(pairs_written[0])
   );

   config_bus_driver #(.HOLD_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .config_addr(config_addr[1]), .config_data(config_data[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]), .pairs_written(pairs_written[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Bus monitor: each idle->active transition must match the next queued write.
   always @(negedge clk) begin
      if (reset) begin
         was_act[0] = 1'b0;
         was_act[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic        act;
            logic [63:0] exp_w;
            int          qsz;
            act = (config_addr[d] !== PARK);
            if (act && !was_act[d]) begin
               qsz = (d == 0) ? q0.size() : q1.size();
               check($sformatf("dut%0d_write_expected", d), (qsz != 0) ? 32'd1 : 32'd0, 32'd1);
               if (qsz != 0) begin
                  exp_w = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("dut%0d_bus_addr", d), config_addr[d], exp_w[63:32]);
                  check($sformatf("dut%0d_bus_data", d), config_data[d], exp_w[31:0]);
               end
               plen[d] = 1;
            end else if (act) begin
               plen[d]++;
            end else if (was_act[d]) begin
               check($sformatf("dut%0d_hold_len", d), plen[d], (d == 0) ? 32'd1 : 32'd3);
            end
            was_act[d] = act;
         end
      end
   end

   task automatic do_start(input int d);
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
      xm[d] = '0;
`endif
   endtask

   task automatic send(input int d, input logic [31:0] w, input bit stall);
      int t;
      if (stall) begin
         in_valid[d] = 1'b0;
         @(posedge clk); #1;
      end
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      t = 0;
      while (!in_ready[d] && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check($sformatf("dut%0d_handshake_in_time", d), (t < 50) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic send_pair(input int d, input logic [31:0] a, input logic [31:0] w, input bit stall);
      send(d, a, stall);
      if (d == 0) q0.push_back({a, w});
      else        q1.push_back({a, w});
      send(d, w, stall);
`ifdef CONFIG_CHECKSUM_EN
      xm[d] = xm[d] ^ a ^ w;
`endif
   endtask

   task automatic finish_load(input int d, input bit corrupt);
`ifdef CONFIG_CHECKSUM_EN
      send(d, corrupt ? 32'h0 : xm[d], 1'b0);
`else
      if (corrupt) $display("note: no checksum stage in this build");
`endif
   endtask

   task automatic wait_done(input int d, input string tag);
      int t;
      t = 0;
      while (!done[d] && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_done_pulse"}, done[d], 1'b1);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done[d], 1'b0);
      check({tag, "_idle_after_done"}, busy[d], 1'b0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; abort[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0;
         plen[d] = 0; was_act[d] = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
         xm[d] = '0;
`endif
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_config_addr", config_addr[0], PARK);
      check("rst_config_data", config_data[0], 32'h0);
      check("rst_in_ready", in_ready[0], 1'b0);
      check("rst_busy", busy[0], 1'b0);
      check("rst_done", done[0], 1'b0);
      check("rst_err", err[0], 1'b0);
      check("rst_pairs", pairs_written[0], 16'd0);

      // single write
      do_start(0);
      check("start_busy", busy[0], 1'b1);
      check("start_in_ready", in_ready[0], 1'b1);
      send(0, 32'hC0F1_0001, 1'b0);
      send_pair(0, 32'h0007_0003, 32'h0000_00A5, 1'b0);
      finish_load(0, 1'b0);
      wait_done(0, "single");
      check("single_pairs", pairs_written[0], 16'd1);
      check("single_err", err[0], 1'b0);
      check("single_parked", config_addr[0], PARK);

      // three writes with in_valid toggling
      do_start(0);
      send(0, 32'hC0F1_0003, 1'b1);
      send_pair(0, {CONFIG_SB,  16'h0002}, 32'h1111_0001, 1'b1);
      send_pair(0, {CONFIG_CB0, 16'h0002}, 32'h2222_0002, 1'b1);
      send_pair(0, {CONFIG_CLB, 16'h0002}, 32'h3333_0003, 1'b1);
      finish_load(0, 1'b0);
      wait_done(0, "three");
      check("three_pairs", pairs_written[0], 16'd3);
      check("three_err", err[0], 1'b0);

      // bad header, then err cleared by next start
      do_start(0);
      send(0, 32'hDEAD_0002, 1'b0);
      wait_done(0, "badhdr");
      check("badhdr_err", err[0], 1'b1);
      check("badhdr_pairs", pairs_written[0], 16'd0);
      do_start(0);
      check("restart_err_cleared", err[0], 1'b0);
      send(0, 32'hC0F1_0000, 1'b0);
      finish_load(0, 1'b0);
      wait_done(0, "restart");
      check("restart_err", err[0], 1'b0);

      // abort after addr word of second pair
      do_start(0);
      send(0, 32'hC0F1_0003, 1'b0);
      send_pair(0, {CONFIG_CB1, 16'h0010}, 32'h0000_0077, 1'b0);
      send(0, {CONFIG_CLB, 16'h0010}, 1'b0);
      abort[0] = 1'b1;
      @(posedge clk); #1;
      abort[0] = 1'b0;
      check("abort_busy", busy[0], 1'b0);
      check("abort_in_ready", in_ready[0], 1'b0);
      check("abort_parked", config_addr[0], PARK);
      check("abort_pairs", pairs_written[0], 16'd1);
      check("abort_err", err[0], 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_done", done[0], 1'b0);
         @(posedge clk); #1;
      end

      // HOLD_CYCLES=3 with a start while busy
      do_start(1);
      send(1, 32'hC0F1_0002, 1'b0);
      send_pair(1, {CONFIG_SB, 16'h0005}, 32'h0000_005A, 1'b0);
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      send_pair(1, {CONFIG_CLB, 16'h0005}, 32'h0000_003C, 1'b0);
      finish_load(1, 1'b0);
      wait_done(1, "hold3");
      check("hold3_pairs", pairs_written[1], 16'd2);
      check("hold3_err", err[1], 1'b0);
      @(posedge clk); #1;
      check("busy_start_ignored", busy[1], 1'b0);

      // N=0 header: done right after the header (or trailer) handshake
      do_start(1);
      send(1, 32'hC0F1_0000, 1'b0);
      finish_load(1, 1'b0);
      check("n0_done_immediate", done[1], 1'b1);
      wait_done(1, "n0");
      check("n0_pairs", pairs_written[1], 16'd0);
      check("n0_err", err[1], 1'b0);

`ifdef CONFIG_CHECKSUM_EN
      do_start(0);
      send(0, 32'hC0F1_0002, 1'b0);
      send_pair(0, 32'h0004_0001, 32'h0000_0003, 1'b0);
      send_pair(0, 32'h0005_0001, 32'h0000_0001, 1'b0);
      check("chk_model_sum", xm[0], 32'h0001_0002);
      finish_load(0, 1'b0);
      wait_done(0, "chk_good");
      check("chk_good_err", err[0], 1'b0);
      do_start(0);
      send(0, 32'hC0F1_0002, 1'b0);
      send_pair(0, 32'h0004_0001, 32'h0000_0003, 1'b0);
      send_pair(0, 32'h0005_0001, 32'h0000_0001, 1'b0);
      finish_load(0, 1'b1);
      wait_done(0, "chk_bad");
      check("chk_bad_err", err[0], 1'b1);
`endif

      // reset in the middle of a load
      do_start(0);
      send(0, 32'hC0F1_0002, 1'b0);
      send(0, {CONFIG_CB0, 16'h0021}, 1'b0);
      check("midload_pairs_before", pairs_written[0], 16'd0);
      check("midload_busy_before", busy[0], 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_busy", busy[0], 1'b0);
      check("midrst_in_ready", in_ready[0], 1'b0);
      check("midrst_parked", config_addr[0], PARK);
      check("midrst_err", err[0], 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
